// File: rtl/pp_sequencer.sv
// Tiny two-bit sequencer: fetches INC/JNO/HLT opcodes from a 4-word memory and executes them.
// One state per clock; fetch states hold mem_req/mem_addr until mem_ack, so memory wait states simply stretch them.
module pp_sequencer #(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               mem_req,
    output logic [1:0]         mem_addr,
    input  logic               mem_ack,
    input  logic [1:0]         mem_data,
    output logic [1:0]         acc,
    output logic               status,
    output logic [1:0]         pc,
    output logic               busy,
    output logic               halted,
    output logic               error,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_DECODE    = 3'd2,
        ST_FETCH_ARG = 3'd3,
        ST_HALTED    = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [1:0]         r_ir;
    logic [1:0]         w_ir_nxt;
    logic [1:0]         r_pc;
    logic [1:0]         w_pc_nxt;
    logic [1:0]         r_acc;
    logic [1:0]         w_acc_nxt;
    logic               r_status;
    logic               w_status_nxt;
    logic [COUNT_W-1:0] r_retired;
    logic [COUNT_W-1:0] w_retired_nxt;
    logic               w_retire;
    logic               w_clear;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ir_nxt     = r_ir;
        w_pc_nxt     = r_pc;
        w_acc_nxt    = r_acc;
        w_status_nxt = r_status;
        w_retire     = 1'b0;
        w_clear      = 1'b0;

        case (r_state)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_pc_nxt     = 2'b00;
                    w_acc_nxt    = 2'b00;
                    w_status_nxt = 1'b0;
                    w_state_nxt  = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                if (mem_ack) begin
                    w_ir_nxt    = mem_data;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (r_ir)
                    OP_INC: begin
                        // Once status is set the accumulator is frozen; only pc moves.
                        if (!r_status) begin
                            {w_status_nxt, w_acc_nxt} = {1'b0, r_acc} + 3'd1;
                        end
                        w_pc_nxt    = r_pc + 2'd1;
                        w_retire    = 1'b1;
                        w_state_nxt = ST_FETCH_OP;
                    end
                    OP_JNO: begin
                        w_state_nxt = ST_FETCH_ARG;
                    end
                    OP_HLT: begin
                        w_retire    = 1'b1;
                        w_state_nxt = ST_HALTED;
                    end
                    default: begin
                        w_state_nxt = ST_ERROR;
                    end
                endcase
            end
            ST_FETCH_ARG: begin
                if (mem_ack) begin
                    w_pc_nxt    = r_status ? (r_pc + 2'd2) : mem_data;
                    w_retire    = 1'b1;
                    w_state_nxt = ST_FETCH_OP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_retired_nxt = r_retired;
        if (w_clear) begin
            w_retired_nxt = '0;
        end else if (w_retire && (r_retired != {COUNT_W{1'b1}})) begin
            w_retired_nxt = r_retired + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ir      <= 2'b00;
            r_pc      <= 2'b00;
            r_acc     <= 2'b00;
            r_status  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_ir      <= w_ir_nxt;
            r_pc      <= w_pc_nxt;
            r_acc     <= w_acc_nxt;
            r_status  <= w_status_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    // Request and address come straight from the state register, so reset drops them at once.
    assign mem_req  = (r_state == ST_FETCH_OP) || (r_state == ST_FETCH_ARG);
    assign mem_addr = (r_state == ST_FETCH_ARG) ? (r_pc + 2'd1) : r_pc;
    assign busy     = (r_state == ST_FETCH_OP) || (r_state == ST_DECODE) ||
                      (r_state == ST_FETCH_ARG);
    assign halted   = (r_state == ST_HALTED);
    assign error    = (r_state == ST_ERROR);
    assign acc      = r_acc;
    assign status   = r_status;
    assign pc       = r_pc;
    assign retired  = r_retired;

endmodule

// File: tb/tb_pp_sequencer.sv
// Directed bench for pp_sequencer: memory model with programmable ack latency and hand-computed results.
module tb_pp_sequencer;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic       mem_ack  = 1'b0;
    logic [1:0] mem_data = 2'b00;
    logic       mem_req;
    logic [1:0] mem_addr;
    logic [1:0] acc;
    logic       status;
    logic [1:0] pc;
    logic       busy;
    logic       halted;
    logic       error;
    logic [7:0] retired;

    int total = 0;
    int bad   = 0;

    logic [1:0] mem [4];
    int         ack_delay = 0;
    bit         ack_en    = 1'b1;
    bit         late_ack  = 1'b0;
    int         wcnt      = 0;
    logic [1:0] held_addr = 2'b00;
    int         addr_bad  = 0;
    int         n;

    pp_sequencer #(.COUNT_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .acc      (acc),
        .status   (status),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .error    (error),
        .retired  (retired)
    );

    always #5 clock = ~clock;

    // Memory responder: answers each request after ack_delay idle cycles, changing only on negedges.
    always @(negedge clock) begin
        if (late_ack) begin
            mem_ack  = 1'b1;
            mem_data = 2'b11;
        end else if (!mem_req || !ack_en) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else begin
            if (wcnt == 0) begin
                held_addr = mem_addr;
            end else if (mem_addr !== held_addr) begin
                addr_bad++;
            end
            if (wcnt >= ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr];
                wcnt     = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    initial begin
        // Reset state, checked while reset is held low.
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy",    busy,    0);
        chk("rst_halted",  halted,  0);
        chk("rst_error",   error,   0);
        chk("rst_pc",      pc,      0);
        chk("rst_acc",     acc,     0);
        chk("rst_status",  status,  0);
        chk("rst_retired", retired, 0);
        #19 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_no_start", busy, 0);

        // Loop program, zero-wait memory: halt 22 clocks after the start edge.
        mem = '{2'b00, 2'b01, 2'b00, 2'b10};
        ack_delay = 0;
        pulse_start();
        n = 0;
        while (!halted && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("p1_halt_cycles", n, 22);
        chk("p1_acc",     acc,     0);
        chk("p1_status",  status,  1);
        chk("p1_pc",      pc,      3);
        chk("p1_retired", retired, 9);
        chk("p1_busy",    busy,    0);

        // Restart from HALTED with two wait states; a start while busy must be ignored.
        ack_delay = 2;
        addr_bad  = 0;
        pulse_start();
        chk("p2_clr_pc",      pc,      0);
        chk("p2_clr_acc",     acc,     0);
        chk("p2_clr_status",  status,  0);
        chk("p2_clr_retired", retired, 0);
        chk("p2_busy",        busy,    1);
        n = 0;
        while (!halted && n < 400) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
        end
        start = 1'b0;
        chk("p2_halt_cycles", n, 48);
        chk("p2_acc",        acc,      0);
        chk("p2_status",     status,   1);
        chk("p2_pc",         pc,       3);
        chk("p2_retired",    retired,  9);
        chk("p2_addr_moved", addr_bad, 0);

        // Illegal opcode at address 1.
        mem = '{2'b00, 2'b11, 2'b00, 2'b00};
        ack_delay = 0;
        pulse_start();
        n = 0;
        while (!error && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("ill_error",   error,   1);
        chk("ill_pc",      pc,      1);
        chk("ill_acc",     acc,     1);
        chk("ill_status",  status,  0);
        chk("ill_retired", retired, 1);
        repeat (5) @(posedge clock);
        #1;
        chk("ill_mem_req_after", mem_req, 0);
        chk("ill_busy_after",    busy,    0);

        // All-INC program: overflow, frozen acc, pc wrap, retired saturation.
        mem = '{2'b00, 2'b00, 2'b00, 2'b00};
        pulse_start();
        n = 0;
        while (retired != 8'd4 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("inc4_acc",    acc,    0);
        chk("inc4_status", status, 1);
        chk("inc4_pc",     pc,     0);
        n = 0;
        while (retired != 8'd6 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("inc6_acc", acc, 0);
        chk("inc6_pc",  pc,  2);
        n = 0;
        while (retired != 8'd255 && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
        end
        repeat (20) @(posedge clock);
        #1;
        chk("sat_retired", retired, 255);
        chk("sat_acc",     acc,     0);
        chk("sat_status",  status,  1);
        chk("sat_busy",    busy,    1);

        // Reset mid-FETCH_ARG with the memory stalled, then a stray late ack.
        @(negedge clock);
        reset = 1'b0;
        #2 reset = 1'b1;
        mem = '{2'b00, 2'b01, 2'b11, 2'b10};
        pulse_start();
        n = 0;
        while (!(mem_req && mem_addr == 2'd2) && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        ack_en = 1'b0;
        chk("arg_pre_acc", acc, 1);
        repeat (2) @(posedge clock);
        #1;
        chk("arg_stalled_req", mem_req, 1);
        #3 reset = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_busy",    busy,    0);
        chk("arst_pc",      pc,      0);
        chk("arst_acc",     acc,     0);
        chk("arst_retired", retired, 0);
        late_ack = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("late_ack_busy",    busy,    0);
        chk("late_ack_mem_req", mem_req, 0);
        chk("late_ack_pc",      pc,      0);
        chk("late_ack_retired", retired, 0);
        late_ack = 1'b0;
        ack_en   = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pp_sequencer.md
PP_SEQUENCER -- requirements
Module: pp_sequencer

Interface
REQ-001 The block SHALL have the following parameter: COUNT_W, default 8, width of the retired-instruction counter.
REQ-002 The block SHALL have the following ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  run request, single-cycle pulse
- mem_req  output  1  instruction memory read request
- mem_addr  output  2  read address, valid while mem_req=1
- mem_ack  input  1  memory response valid; mem_data sampled on the same edge
- mem_data  input  2  instruction word or operand word
- acc  output  2  value register
- status  output  1  overflow/status flag
- pc  output  2  program counter
- busy  output  1  high in any state other than IDLE, HALTED or ERROR
- halted  output  1  high in HALTED
- error  output  1  high in ERROR
- retired  output  COUNT_W  count of instructions completed since the last start

Function
REQ-003 Opcodes SHALL be as follows:
- 00 INC
- 01 JNO, a two-word instruction whose next word is the 2-bit target
- 10 HLT
- 11 illegal
REQ-004 The state machine SHALL have the states IDLE, FETCH_OP, DECODE, FETCH_ARG, HALTED and ERROR, with one state per clock minimum.
REQ-005 In IDLE, HALTED or ERROR, a start sample SHALL clear pc, acc, status and retired to 0 and enter FETCH_OP.
REQ-006 start SHALL be ignored in FETCH_OP, DECODE and FETCH_ARG.
REQ-007 FETCH_OP SHALL drive mem_req=1 and mem_addr=pc, holding both stable until mem_ack=1.
REQ-008 On a FETCH_OP edge with mem_ack=1, the block SHALL latch mem_data into the internal instruction register and enter DECODE.
REQ-009 mem_ack MAY be high in the first request cycle (zero wait).
REQ-010 mem_ack and mem_data SHALL be ignored whenever mem_req=0.
REQ-011 In DECODE, INC with status=0 SHALL perform {carry, acc} = acc + 1 (2-bit wrap, 11 -> 00), set status to carry, set pc to pc+1 mod 4, increment retired, and enter FETCH_OP.
REQ-012 In DECODE, INC with status=1 SHALL leave acc and status unchanged, advance pc by 1, and increment retired.
REQ-013 In DECODE, JNO SHALL enter FETCH_ARG with no other update.
REQ-014 FETCH_ARG SHALL drive mem_req=1 and mem_addr=pc+1 mod 4 until mem_ack.
REQ-015 On the FETCH_ARG ack edge, the block SHALL set pc to mem_data if status=0, or to pc+2 mod 4 if status=1, then increment retired and enter FETCH_OP.
REQ-016 In DECODE, HLT SHALL increment retired and enter HALTED, leaving pc at the HLT address.
REQ-017 In DECODE, opcode 11 SHALL enter ERROR with pc at the offending address, and retired SHALL NOT increment.
REQ-018 retired SHALL saturate at all-ones and never wrap.
REQ-019 mem_req SHALL be a registered-state decode: high only in FETCH_OP and FETCH_ARG, low in all other states.
REQ-020 halted, error and busy SHALL be pure decodes of the current state.
REQ-021 acc, status and pc SHALL change only on the transitions listed above.

Reset
REQ-022 reset=0 SHALL, asynchronously and regardless of clock, force state to IDLE and all of the following to 0: pc, acc, status, retired, mem_req, busy, halted and error.
REQ-023 Reset asserted mid-fetch SHALL drop mem_req immediately, and any mem_ack arriving during or after the reset SHALL be ignored.
REQ-024 After reset deasserts, the block SHALL remain in IDLE until a start sample.

Verification
REQ-025 Memory {00,01,00,10}, mem_ack tied 1, start pulse -> halted rises exactly 22 clocks after the start edge, with acc=00, status=1, pc=11 and retired=9.
REQ-026 Same program with mem_ack delayed 2 cycles per request -> identical final acc, status, pc and retired, with mem_addr stable throughout every wait.
REQ-027 Memory {00,11,xx,xx}, start -> error=1, pc=01, acc=01, retired=1, and mem_req=0 thereafter.
REQ-028 Memory {00,00,00,00}, start -> after 4 INCs acc=00 and status=1, then acc holds 00 and pc wraps 11 -> 00 indefinitely with retired counting up and saturating at 255.
REQ-029 reset pulsed low while in FETCH_ARG with mem_ack low -> all outputs 0 and IDLE immediately, and a late mem_ack has no effect.
REQ-030 start pulsed during busy -> ignored; start in HALTED -> restart from pc=00 with acc, status and retired cleared.
